regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the WRITE write ports of the multi-port `regfile` among REQ writeback requesters.
- Requesters include ALU pipes, the load unit and the multiplier.
- Each cycle it grants up to WRITE requests in round-robin order and drops writes to the hard-wired zero register.
- Granted writes are registered and driven onto regfile waddr/wdata/we_ one cycle later. It sits between the execute/writeback stages and `regfile`.

Parameters:
- DATA, 32, data width (matches regfile DATA)
- ADDR, 5, register address width (matches regfile ADDR)
- REQ, 6, number of writeback requesters
- WRITE, 4, number of regfile write ports
- ZERO_REG, `Enable, address 0 is hard-wired zero; writes to it are absorbed
- RRW, $clog2(REQ), round-robin pointer width (localparam)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  when high, no request is granted this cycle
- req_valid  in  REQ  per-requester write request
- req_addr  in  ADDR*REQ  destination register, requester i at [i*ADDR +: ADDR]
- req_data  in  DATA*REQ  write data, requester i at [i*DATA +: DATA]
- req_ready  out  REQ  grant; transfer occurs when req_valid[i] & req_ready[i]
- waddr  out  ADDR*WRITE  to regfile waddr (registered)
- wdata  out  DATA*WRITE  to regfile wdata (registered)
- we_  out  WRITE  to regfile we_, active-low (registered)
- conflict_cnt  out  16  saturating count of cycles with at least one valid request left ungranted

Behaviour:
- Reset (reset low, async):
  - we_ = all `Disable_ (all 1); waddr = 0; wdata = 0.
  - rr_ptr = 0; conflict_cnt = 0.
  - req_ready = 0 while reset is asserted.
- Priority order each cycle: requesters rr_ptr, rr_ptr+1, ..., wrapping modulo REQ.
- Grant rules, walking the priority order (combinational, same cycle as req_valid):
  - Zero-register absorb: if ZERO_REG and addr==0, grant and do not consume a port; no regfile write results.
  - Otherwise grant only if a port is still free and no higher-priority request granted this cycle has the same address.
  - A same-address loser waits with req_ready=0 and must hold valid/addr/data stable until granted.
  - Port assignment: non-zero grants fill ports 0,1,2,... in priority order; unused ports are disabled.
- stall=1: req_ready = 0 for all requesters, including zero-register writes; next-cycle we_ = all 1; rr_ptr unchanged.
- Output latency: 1 cycle. A grant in cycle t appears as we_[p]=0, waddr[p], wdata[p] in cycle t+1. Regfile write completes at the t+1 edge.
- Ungranted ports: we_[p] = 1; waddr/wdata hold their previous value (don't-care).
- rr_ptr update:
  - If at least one grant (including absorbed zero writes): rr_ptr = (index of lowest-priority granted requester + 1) mod REQ.
  - Otherwise rr_ptr is unchanged.
  - Guarantees a continuously valid requester is granted within ceil(REQ/WRITE)+1 cycles (same-address chains excepted).
- conflict_cnt: increments when stall=0 and any (req_valid & ~req_ready) bit is set. Saturates at 16'hFFFF; no wrap.
- Boundaries:
  - REQ <= WRITE: every non-conflicting request is granted.
  - All requests target address 0: all granted, we_ stays all 1.
  - Reset asserted mid-cycle: in-flight registered writes are discarded (we_ forced to 1 immediately).

Decomposition:
- Shared package `regfile_pkg`: DATA/ADDR defaults, write-port struct typedef {addr, data, we_}, ZERO_ADDR constant.
- One natural sub-module: `rr_port_alloc`, combinational.
  - Inputs: rotated valid vector, addresses and port count.
  - Outputs: grant vector, per-port requester index, per-port enable.
- Top level holds rr_ptr, output registers and conflict_cnt.

Test Plan:
- Reset: reset low for 1 step -> we_=4'b1111, req_ready=0, conflict_cnt=0; after release with no valid, we_ stays 4'b1111.
- Basic fill: reqs 0-3 valid, addrs 1,2,3,31, data 1,2,3,31 -> all ready in cycle t; cycle t+1 we_=4'b0000, waddr ports {1,2,3,31}; next cycle rr_ptr=4; regfile reads 1,2,3,31 back.
- Oversubscription: 6 reqs valid (addrs 4-9), held until granted:
  - Cycle 1: reqs 0-3 granted.
  - Cycle 2: reqs 4,5 granted, we_=4'b1100.
  - conflict_cnt = 1.
- Zero absorb: req0 addr 0 data 32'hdeadbeef, reqs 1-4 addrs 10-13 -> all five ready in one cycle; 4 ports used for 10-13; reg[0] still reads 0.
- Same-address conflict: rr_ptr=0, req1 and req3 both addr 7 (data 32'h10 / 32'h30):
  - Cycle 1: req1 granted, req3 ready=0.
  - Cycle 2: req3 granted.
  - Final reg[7] = 32'h30.
- Stall and mid-op reset:
  - stall=1 with 4 valid -> req_ready=0, next we_=4'b1111, rr_ptr unchanged.
  - Assert reset while we_=4'b0000 -> we_ goes to 4'b1111 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, write-port record and ring-index helper for the regfile and its writeback arbiter
//   DATA_W    default data width of the register file
//   ADDR_W    default register address width
//   ZERO_ADDR address of the hard-wired zero register
//   wport_t   one regfile write port {addr, data, active-low we_}
//   rr_wrap   (base + off) mod n, used to walk round-robin priority order
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we_;
  } wport_t;
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/rr_port_alloc.sv
// rr_port_alloc: combinational write-port allocator over a priority-rotated request vector
//   valid_i  rotated request valid, bit 0 is highest priority
//   addr_i   rotated destination addresses, entry k at [k*ADDR +: ADDR]
//   grant_o  rotated grant vector (includes absorbed zero-register writes)
//   sel_o    per-port rotated requester index, port p at [p*RRW +: RRW]
//   en_o     per-port enable; ports fill 0,1,2,... in priority order
module rr_port_alloc
  import regfile_pkg::*;
#(
  parameter int REQ      = 6,
  parameter int WRITE    = 4,
  parameter int ADDR     = ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int RRW      = $clog2(REQ)
) (
  input  logic [REQ-1:0]       valid_i,
  input  logic [ADDR*REQ-1:0]  addr_i,
  output logic [REQ-1:0]       grant_o,
  output logic [WRITE*RRW-1:0] sel_o,
  output logic [WRITE-1:0]     en_o
);
  localparam int UW = $clog2(WRITE + 1);

  logic [UW-1:0] used;
  logic          clash;
  logic          is_zero;

  always_comb begin
    grant_o = '0;
    sel_o   = '0;
    en_o    = '0;
    used    = '0;
    clash   = 1'b0;
    is_zero = 1'b0;
    for (int k = 0; k < REQ; k++) begin
      // a lower-priority writer to an address already granted this cycle must wait,
      // so the regfile never sees two ports hitting the same register
      clash = 1'b0;
      for (int j = 0; j < k; j++)
        clash = clash | (grant_o[j] && addr_i[j*ADDR +: ADDR] == addr_i[k*ADDR +: ADDR]);
      is_zero = (ZERO_REG != 0) && (addr_i[k*ADDR +: ADDR] == ADDR'(ZERO_ADDR));
      if (valid_i[k]) begin
        if (is_zero) begin
          grant_o[k] = 1'b1;
        end else if (used < UW'(WRITE) && !clash) begin
          grant_o[k] = 1'b1;
          for (int p = 0; p < WRITE; p++)
            if (used == UW'(p)) begin
              sel_o[p*RRW +: RRW] = RRW'(k);
              en_o[p]             = 1'b1;
            end
          used = used + UW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the regfile write ports among writeback requesters
//   clk, reset      clock and asynchronous active-low reset
//   stall           blocks every grant this cycle
//   req_valid/addr/data  per-requester write requests (packed, requester i at slice i)
//   req_ready       combinational grant, transfer when req_valid & req_ready
//   waddr/wdata/we_ registered regfile write ports, we_ active-low
//   conflict_cnt    saturating count of cycles leaving a valid request ungranted
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA     = DATA_W,
  parameter int ADDR     = ADDR_W,
  parameter int REQ      = 6,
  parameter int WRITE    = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [REQ-1:0]        req_valid,
  input  logic [ADDR*REQ-1:0]   req_addr,
  input  logic [DATA*REQ-1:0]   req_data,
  output logic [REQ-1:0]        req_ready,
  output logic [ADDR*WRITE-1:0] waddr,
  output logic [DATA*WRITE-1:0] wdata,
  output logic [WRITE-1:0]      we_,
  output logic [15:0]           conflict_cnt
);
  localparam int RRW = $clog2(REQ);

  logic [RRW-1:0]        rr_q, rr_d;
  logic [ADDR*WRITE-1:0] waddr_q, waddr_d;
  logic [DATA*WRITE-1:0] wdata_q, wdata_d;
  logic [WRITE-1:0]      we_q, we_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [REQ-1:0]        rot_valid;
  logic [ADDR*REQ-1:0]   rot_addr;
  logic [REQ-1:0]        grant_rot;
  logic [WRITE*RRW-1:0]  port_sel;
  logic [WRITE-1:0]      port_en;

  // rotate requests so the allocator always sees rr_q as index 0
  always_comb begin
    rot_valid = '0;
    rot_addr  = '0;
    for (int k = 0; k < REQ; k++) begin
      rot_valid[k]              = req_valid[rr_wrap(int'(rr_q), k, REQ)];
      rot_addr[k*ADDR +: ADDR]  = req_addr[rr_wrap(int'(rr_q), k, REQ)*ADDR +: ADDR];
    end
  end

  rr_port_alloc #(
    .REQ      (REQ),
    .WRITE    (WRITE),
    .ADDR     (ADDR),
    .ZERO_REG (ZERO_REG),
    .RRW      (RRW)
  ) u_alloc (
    .valid_i (rot_valid),
    .addr_i  (rot_addr),
    .grant_o (grant_rot),
    .sel_o   (port_sel),
    .en_o    (port_en)
  );

  // un-rotate grants; reset is folded in so nothing transfers while it is held
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < REQ; k++)
      req_ready[rr_wrap(int'(rr_q), k, REQ)] = grant_rot[k] & ~stall & reset;
  end

  // the last granted entry in priority order is the lowest-priority winner
  always_comb begin
    rr_d = rr_q;
    for (int k = 0; k < REQ; k++)
      if (grant_rot[k] && !stall) rr_d = RRW'(rr_wrap(int'(rr_q), k + 1, REQ));
  end

  // idle ports keep their last address/data and only drop we_
  always_comb begin
    int src;
    src     = 0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = '1;
    for (int p = 0; p < WRITE; p++)
      if (port_en[p] && !stall) begin
        src                      = rr_wrap(int'(rr_q), int'(port_sel[p*RRW +: RRW]), REQ);
        waddr_d[p*ADDR +: ADDR]  = req_addr[src*ADDR +: ADDR];
        wdata_d[p*DATA +: DATA]  = req_data[src*DATA +: DATA];
        we_d[p]                  = 1'b0;
      end
  end

  assign cnt_d = (!stall && |(req_valid & ~req_ready) && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= '1;
      cnt_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign we_          = we_q;
  assign conflict_cnt = cnt_q;
endmodule
